stream_arbiter: RTL and testbench

//  Shares one valid/ready/eot stream consumer between N_REQ producer streams (e.g. classifier stages returning
//  to a common scale/feature unit). Round-robin grant, held for a whole transaction until the beat carrying
//  eot[LOCK_LEVEL] is accepted. Registered output stage; full throughput while locked. Inverse of the fan-out

---
 rtl/cc_stream_pkg.sv | 7 +
 rtl/rr_arbiter.sv | 22 ++
 rtl/stream_arbiter.sv | 85 ++++++++
 tb/tb_stream_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cc_stream_pkg.sv
// cc_stream_pkg: shared stream types, eot bit indices and arbiter states
package cc_stream_pkg;
  typedef logic [1:0] eot_t;
  localparam int EOT_ROW = 0;
  localparam int EOT_FRAME = 1;
  typedef enum logic {S_IDLE, S_LOCKED} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching from last_grant+1 with wrap
module rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last_grant,
  output logic [$clog2(N_REQ)-1:0] grant,
  output logic                     any_req
);
  localparam int IW = $clog2(N_REQ);
  logic [IW-1:0] idx;
  // Walk farthest-first so the nearest requester after last_grant wins.
  always_comb begin
    grant = '0;
    idx = '0;
    any_req = |req;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = IW'((int'(last_grant) + k) % N_REQ);
      if (req[idx]) grant = idx;
    end
  end
endmodule

// File: rtl/stream_arbiter.sv
// stream_arbiter: round-robin merge of N_REQ valid/ready/eot streams, grant held until eot[LOCK_LEVEL]
module stream_arbiter
  import cc_stream_pkg::*;
#(
  parameter int W_DATA = 8,
  parameter int N_REQ = 2,
  parameter int LOCK_LEVEL = EOT_FRAME
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          din_valid,
  output logic [N_REQ-1:0]          din_ready,
  input  logic [N_REQ*W_DATA-1:0]   din_data,
  input  logic [N_REQ*2-1:0]        din_eot,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic [W_DATA-1:0]         dout_data,
  output logic [1:0]                dout_eot,
  output logic [$clog2(N_REQ)-1:0]  dout_grant
);
  localparam int IW = $clog2(N_REQ);
  state_t state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, last_q, last_d, arb_idx, dout_grant_q, dout_grant_d;
  logic [W_DATA-1:0] dout_data_q, dout_data_d, beat_data;
  eot_t dout_eot_q, dout_eot_d, beat_eot;
  logic dout_valid_q, dout_valid_d, beat_valid, any_req, can_take, ld, rel;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req       (din_valid),
    .last_grant(last_q),
    .grant     (arb_idx),
    .any_req   (any_req)
  );

  always_comb begin
    beat_data = '0;
    beat_eot = '0;
    beat_valid = 1'b0;
    can_take = state_q == S_LOCKED && (!dout_valid_q || dout_ready);
    din_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q == IW'(i)) begin
        beat_data = din_data[i*W_DATA +: W_DATA];
        beat_eot = din_eot[i*2 +: 2];
        beat_valid = din_valid[i];
        din_ready[i] = can_take;
      end
    end
    ld = can_take && beat_valid;
    rel = ld && beat_eot[LOCK_LEVEL];
    state_d = state_q == S_IDLE ? (any_req ? S_LOCKED : S_IDLE) : (rel ? S_IDLE : S_LOCKED);
    grant_d = state_q == S_IDLE && any_req ? arb_idx : grant_q;
    last_d = rel ? grant_q : last_q;
    dout_valid_d = ld || (dout_valid_q && !dout_ready);
    dout_data_d = ld ? beat_data : dout_data_q;
    dout_eot_d = ld ? beat_eot : dout_eot_q;
    dout_grant_d = ld ? grant_q : dout_grant_q;
  end

  // last_q resets to the top index so the first search begins at requester 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q <= IW'(N_REQ - 1);
      dout_valid_q <= 1'b0;
      dout_data_q <= '0;
      dout_eot_q <= '0;
      dout_grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      dout_valid_q <= dout_valid_d;
      dout_data_q <= dout_data_d;
      dout_eot_q <= dout_eot_d;
      dout_grant_q <= dout_grant_d;
    end
  end

  assign dout_valid = dout_valid_q;
  assign dout_data = dout_data_q;
  assign dout_eot = dout_eot_q;
  assign dout_grant = dout_grant_q;
endmodule

// File: tb/tb_stream_arbiter.sv
// tb_stream_arbiter: scoreboard bench for a frame-locked (dut 0) and a row-locked (dut 1) arbiter
module tb_stream_arbiter;
  typedef struct packed {logic [7:0] d; logic [1:0] e;} beat_t;
  typedef struct packed {logic [0:0] g; logic [1:0] e; logic [7:0] d;} want_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] din_valid[2], din_ready[2];
  logic [15:0] din_data[2];
  logic [3:0] din_eot[2];
  logic dout_valid[2];
  logic dout_ready[2] = '{1'b1, 1'b1};
  logic [7:0] dout_data[2];
  logic [1:0] dout_eot[2];
  logic [0:0] dout_grant[2];
  beat_t src_q[4][$];
  want_t want_q[2][$];
  want_t popped;
  int pause[4] = '{0, 0, 0, 0};
  logic fired[4] = '{0, 0, 0, 0};
  logic [1:0] rdy_mode[2] = '{2'd1, 2'd1};
  logic prev_stall[2] = '{0, 0};
  logic [10:0] prev_out[2];
  int n_chk = 0, n_fail = 0, cyc = 0;

  stream_arbiter #(.W_DATA(8), .N_REQ(2), .LOCK_LEVEL(1)) u_frame (
    .clk(clk), .rst(rst), .din_valid(din_valid[0]), .din_ready(din_ready[0]),
    .din_data(din_data[0]), .din_eot(din_eot[0]), .dout_valid(dout_valid[0]),
    .dout_ready(dout_ready[0]), .dout_data(dout_data[0]), .dout_eot(dout_eot[0]),
    .dout_grant(dout_grant[0])
  );
  stream_arbiter #(.W_DATA(8), .N_REQ(2), .LOCK_LEVEL(0)) u_row (
    .clk(clk), .rst(rst), .din_valid(din_valid[1]), .din_ready(din_ready[1]),
    .din_data(din_data[1]), .din_eot(din_eot[1]), .dout_valid(dout_valid[1]),
    .dout_ready(dout_ready[1]), .dout_data(dout_data[1]), .dout_eot(dout_eot[1]),
    .dout_grant(dout_grant[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic src(int k, logic [7:0] d, logic [1:0] e);
    src_q[k].push_back('{d: d, e: e});
  endtask

  task automatic want(int u, logic g, logic [7:0] d, logic [1:0] e);
    want_q[u].push_back('{g: g, e: e, d: d});
  endtask

  task automatic wait_drain(int u);
    for (int i = 0; i < 200 && want_q[u].size() != 0; i++) @(negedge clk);
    check($sformatf("drain_dut%0d_left", u), want_q[u].size(), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Producers: pop on last cycle's handshake, then present the head beat unless paused.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 4; k++)
      if (fired[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
    for (int u = 0; u < 2; u++) begin
      for (int r = 0; r < 2; r++) begin
        din_valid[u][r] = src_q[u*2+r].size() > 0 && pause[u*2+r] == 0;
        din_data[u][r*8 +: 8] = src_q[u*2+r].size() > 0 ? src_q[u*2+r][0].d : 8'h00;
        din_eot[u][r*2 +: 2] = src_q[u*2+r].size() > 0 ? src_q[u*2+r][0].e : 2'b00;
        if (pause[u*2+r] > 0) pause[u*2+r]--;
      end
      dout_ready[u] = rdy_mode[u] == 2'd2 ? ~dout_ready[u] : rdy_mode[u][0];
    end
  end

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      fired[u*2] = din_valid[u][0] & din_ready[u][0];
      fired[u*2+1] = din_valid[u][1] & din_ready[u][1];
      if (rst) prev_stall[u] = 1'b0;
      else begin
        check($sformatf("ready_onehot_dut%0d", u), 32'($countones(din_ready[u]) <= 1), 1);
        if (prev_stall[u]) check($sformatf("stall_hold_dut%0d", u),
                                 {dout_grant[u], dout_eot[u], dout_data[u]}, prev_out[u]);
        if (dout_valid[u] && dout_ready[u]) begin
          if (want_q[u].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL spurious_beat_dut%0d: got 0x%0h required no beat", u, dout_data[u]);
          end else begin
            popped = want_q[u].pop_front();
            check($sformatf("beat_dut%0d", u), {dout_grant[u], dout_eot[u], dout_data[u]}, popped);
          end
        end
        prev_stall[u] = dout_valid[u] && !dout_ready[u];
        prev_out[u] = {dout_grant[u], dout_eot[u], dout_data[u]};
      end
    end
  end

  initial begin
    int t0, t1, nv, first, last;
    logic bad;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("rst_dout_valid", dout_valid[u], 0);
      check("rst_din_ready", din_ready[u], 0);
      check("rst_dout_data", dout_data[u], 0);
      check("rst_dout_eot", dout_eot[u], 0);
      check("rst_dout_grant", dout_grant[u], 0);
    end
    rst = 1'b0;
    // single requester, latency and throughput
    src(0, 8'h11, 2'b00); src(0, 8'h22, 2'b00); src(0, 8'h33, 2'b10);
    want(0, 0, 8'h11, 2'b00); want(0, 0, 8'h22, 2'b00); want(0, 0, 8'h33, 2'b10);
    t0 = -1; t1 = -1; nv = 0; bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (din_valid[0][0] && t0 < 0) t0 = cyc;
      if (dout_valid[0] && t1 < 0) t1 = cyc;
      if (dout_valid[0]) nv++;
      if (din_ready[0][1]) bad = 1'b1;
    end
    check("t1_first_out_latency", t1 - t0, 2);
    check("t1_valid_cycles", nv, 3);
    check("t1_req1_ready", bad, 0);
    wait_drain(0);
    // two competing requesters: frame, frame, frame with one idle cycle between
    pulse_reset();
    src(0, 8'h01, 2'b00); src(0, 8'h02, 2'b10); src(0, 8'h05, 2'b00); src(0, 8'h06, 2'b10);
    src(1, 8'h03, 2'b00); src(1, 8'h04, 2'b10);
    want(0, 0, 8'h01, 2'b00); want(0, 0, 8'h02, 2'b10); want(0, 1, 8'h03, 2'b00);
    want(0, 1, 8'h04, 2'b10); want(0, 0, 8'h05, 2'b00); want(0, 0, 8'h06, 2'b10);
    first = -1; last = -1; nv = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dout_valid[0]) begin
        if (first < 0) first = cyc;
        last = cyc;
        nv++;
      end
    end
    check("t2_output_span", last - first + 1, 8);
    check("t2_valid_cycles", nv, 6);
    wait_drain(0);
    // row-level release on the second arbiter
    src(3, 8'hA1, 2'b10); src(3, 8'hA2, 2'b01); src(3, 8'hA3, 2'b01);
    want(1, 1, 8'hA1, 2'b10); want(1, 1, 8'hA2, 2'b01);
    want(1, 0, 8'hB1, 2'b11); want(1, 1, 8'hA3, 2'b01);
    repeat (2) @(negedge clk);
    src(2, 8'hB1, 2'b11);
    wait_drain(1);
    // back-pressure 1010... across a 4-beat frame
    rdy_mode[0] = 2'd2;
    src(0, 8'hC1, 2'b00); src(0, 8'hC2, 2'b00); src(0, 8'hC3, 2'b00); src(0, 8'hC4, 2'b10);
    want(0, 0, 8'hC1, 2'b00); want(0, 0, 8'hC2, 2'b00); want(0, 0, 8'hC3, 2'b00);
    want(0, 0, 8'hC4, 2'b10);
    wait_drain(0);
    rdy_mode[0] = 2'd1;
    repeat (2) @(negedge clk);
    // granted requester stalls mid-frame while the other waits
    src(0, 8'hD1, 2'b00); src(0, 8'hD2, 2'b00); src(0, 8'hD3, 2'b00); src(0, 8'hD4, 2'b10);
    want(0, 0, 8'hD1, 2'b00); want(0, 0, 8'hD2, 2'b00); want(0, 0, 8'hD3, 2'b00);
    want(0, 0, 8'hD4, 2'b10); want(0, 1, 8'hE1, 2'b10);
    bad = 1'b1;
    for (int i = 0; i < 20 && bad; i++) begin
      @(negedge clk);
      if (din_valid[0][0] && din_ready[0][0]) bad = 1'b0;
    end
    check("t5_first_accept_seen", bad, 0);
    pause[0] = 5;
    src(1, 8'hE1, 2'b10);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (din_ready[0][1]) bad = 1'b1;
    end
    check("t5_req1_ready_while_locked", bad, 0);
    wait_drain(0);
    // reset while an output beat is held
    rdy_mode[0] = 2'd0;
    src(0, 8'hF1, 2'b00); src(0, 8'hF2, 2'b00); src(0, 8'hF3, 2'b00); src(0, 8'hF4, 2'b10);
    want(0, 0, 8'hF1, 2'b00);
    bad = 1'b1;
    for (int i = 0; i < 20 && bad; i++) begin
      @(negedge clk);
      if (dout_valid[0]) bad = 1'b0;
    end
    check("t6_held_beat_seen", bad, 0);
    rst = 1'b1;
    src_q[0].delete();
    want_q[0].delete();
    @(negedge clk);
    check("t6_rst_dout_valid", dout_valid[0], 0);
    check("t6_rst_din_ready", din_ready[0], 0);
    check("t6_rst_dout_data", dout_data[0], 0);
    rst = 1'b0;
    rdy_mode[0] = 2'd1;
    src(1, 8'h5A, 2'b10);
    want(0, 1, 8'h5A, 2'b10);
    wait_drain(0);
    repeat (3) @(negedge clk);
    check("final_dut1_left", want_q[1].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
